// File: rtl/tone_sequencer.sv
// Plays a stored color pattern as timed tones with gaps, plus key-feedback
// and error tones; one shared down-counter times every state.
module tone_sequencer #(
   parameter int TONE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int KEY_CYCLES  = 10_000_000,
   parameter int ERR_CYCLES  = 50_000_000,
   parameter int HW0         = 119617,
   parameter int HW1         = 99206,
   parameter int HW2         = 80645,
   parameter int HW3         = 60241,
   parameter int HWERR       = 595238
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  length,
   output logic [4:0]  pat_addr,
   input  logic [1:0]  pat_data,
   input  logic        key_req,
   input  logic [1:0]  key_color,
   input  logic        err_req,
   output logic [19:0] half_wav,
   output logic        audio_res,
   output logic [2:0]  lamp,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, FETCH, TONE, GAP, KEY, ERR} state_t;

   localparam logic [25:0] FETCH_LD = 26'd1;
   localparam logic [25:0] TONE_LD  = 26'(TONE_CYCLES - 1);
   localparam logic [25:0] GAP_LD   = 26'(GAP_CYCLES - 1);
   localparam logic [25:0] KEY_LD   = 26'(KEY_CYCLES - 1);
   localparam logic [25:0] ERR_LD   = 26'(ERR_CYCLES - 1);

   state_t      state_q, state_d;
   logic [25:0] cnt_q, cnt_d;
   logic [5:0]  n_q, n_d;
   logic [5:0]  step_q, step_d;
   logic [4:0]  pat_addr_q, pat_addr_d;
   logic [19:0] half_wav_q, half_wav_d;
   logic        audio_res_q, audio_res_d;
   logic [2:0]  lamp_q, lamp_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   function automatic logic [19:0] hw_sel(input logic [1:0] color);
      case (color)
         2'd0:    hw_sel = 20'(HW0);
         2'd1:    hw_sel = 20'(HW1);
         2'd2:    hw_sel = 20'(HW2);
         default: hw_sel = 20'(HW3);
      endcase
   endfunction

   function automatic logic [2:0] lamp_sel(input logic [1:0] color);
      lamp_sel = {1'b0, color} + 3'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != 26'd0) ? cnt_q - 26'd1 : 26'd0;
      n_d         = n_q;
      step_d      = step_q;
      pat_addr_d  = pat_addr_q;
      half_wav_d  = half_wav_q;
      audio_res_d = audio_res_q;
      lamp_d      = lamp_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (length == 6'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = FETCH;
                  cnt_d      = FETCH_LD;
                  n_d        = (length > 6'd32) ? 6'd32 : length;
                  step_d     = 6'd0;
                  pat_addr_d = 5'd0;
                  busy_d     = 1'b1;
               end
            end else if (key_req) begin
               state_d     = KEY;
               cnt_d       = KEY_LD;
               half_wav_d  = hw_sel(key_color);
               audio_res_d = 1'b0;
               lamp_d      = lamp_sel(key_color);
               busy_d      = 1'b1;
            end
         end
         FETCH: begin
            // pat_data is valid on the second FETCH cycle; use it directly.
            if (cnt_q == 26'd0) begin
               state_d     = TONE;
               cnt_d       = TONE_LD;
               half_wav_d  = hw_sel(pat_data);
               audio_res_d = 1'b0;
               lamp_d      = lamp_sel(pat_data);
            end
         end
         TONE: begin
            if (cnt_q == 26'd0) begin
               state_d     = GAP;
               cnt_d       = GAP_LD;
               audio_res_d = 1'b1;
               lamp_d      = 3'd0;
            end
         end
         GAP: begin
            if (cnt_q == 26'd0) begin
               if (step_q + 6'd1 == n_q) begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  step_d     = 6'd0;
                  pat_addr_d = 5'd0;
               end else begin
                  state_d    = FETCH;
                  cnt_d      = FETCH_LD;
                  step_d     = step_q + 6'd1;
                  pat_addr_d = pat_addr_q + 5'd1;
               end
            end
         end
         KEY: begin
            if (key_req) begin
               cnt_d      = KEY_LD;
               half_wav_d = hw_sel(key_color);
               lamp_d     = lamp_sel(key_color);
            end else if (cnt_q == 26'd0) begin
               state_d     = IDLE;
               audio_res_d = 1'b1;
               lamp_d      = 3'd0;
               busy_d      = 1'b0;
            end
         end
         ERR: begin
            if (cnt_q == 26'd0) begin
               state_d     = IDLE;
               audio_res_d = 1'b1;
               lamp_d      = 3'd0;
               busy_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Error tone overrides everything, including any done pulse.
      if (err_req) begin
         state_d     = ERR;
         cnt_d       = ERR_LD;
         half_wav_d  = 20'(HWERR);
         audio_res_d = 1'b0;
         lamp_d      = 3'd5;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         step_d      = 6'd0;
         pat_addr_d  = 5'd0;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 26'd0;
         n_q         <= 6'd0;
         step_q      <= 6'd0;
         pat_addr_q  <= 5'd0;
         half_wav_q  <= 20'd0;
         audio_res_q <= 1'b1;
         lamp_q      <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         step_q      <= step_d;
         pat_addr_q  <= pat_addr_d;
         half_wav_q  <= half_wav_d;
         audio_res_q <= audio_res_d;
         lamp_q      <= lamp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pat_addr  = pat_addr_q;
   assign half_wav  = half_wav_q;
   assign audio_res = audio_res_q;
   assign lamp      = lamp_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  TONE_CYCLES  25_000_000  sequence tone length, cycles.
  GAP_CYCLES  12_500_000  silence after each sequence tone, cycles.
  KEY_CYCLES  10_000_000  key-feedback tone length, cycles.
  ERR_CYCLES  50_000_000  error tone length, cycles.
  HW0..HW3  119617, 99206, 80645, 60241  half_wav for colors 0..3.
  HWERR  595238  half_wav for the error tone.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  CLOCK_50  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  start  in  1  pulse; play the stored pattern.
  length  in  6  number of steps to play, 0..32.
  pat_addr  out  5  pattern memory address.
  pat_data  in  2  color at pat_addr, valid 1 cycle after pat_addr changes.
  key_req  in  1  pulse; user key-feedback tone.
  key_color  in  2  color for key_req.
  err_req  in  1  pulse; error tone.
  half_wav  out  20  oscillator half-period, cycles.
  audio_res  out  1  1 = oscillator/codec held silent.
  lamp  out  3  0 none, 1..4 = color+1 lit, 5 = error.
  busy  out  1  sequence, key or error tone in progress.
  done  out  1  1-cycle pulse at sequence completion.

Function
REQ-003 SHALL use states IDLE, FETCH, TONE, GAP, KEY, ERR.
REQ-004 SHALL, in IDLE, assert audio_res=1, lamp=0, busy=0, half_wav unchanged.
REQ-005 SHALL, on start in IDLE, latch n=min(length,32), set pat_addr=0, step=0, go to FETCH.
REQ-006 SHALL, on start in IDLE with length=0, pulse done the next cycle and stay in IDLE.
REQ-007 SHALL spend exactly 2 cycles in FETCH: 1 cycle waiting on memory latency, then latch pat_data; then enter TONE.
REQ-008 SHALL, in TONE, drive half_wav=HW[color], audio_res=0, lamp=color+1 for exactly TONE_CYCLES cycles, then enter GAP.
REQ-009 SHALL, in GAP, drive audio_res=1, lamp=0 for exactly GAP_CYCLES cycles; then increment step and pat_addr; if step+1=n, pulse done and go to IDLE, else go to FETCH.
REQ-010 SHALL, on key_req in IDLE, drive half_wav=HW[key_color], audio_res=0, lamp=key_color+1 for KEY_CYCLES cycles, then return to IDLE.
REQ-011 SHALL, on key_req in KEY, restart the KEY timer with the new key_color.
REQ-012 SHALL ignore key_req in FETCH, TONE, GAP and ERR, and ignore start in every state except IDLE.
REQ-013 SHALL, on err_req in any state, abort the current activity without a done pulse, drive half_wav=HWERR, audio_res=0, lamp=5 for ERR_CYCLES cycles, then return to IDLE.
REQ-014 SHALL apply priority err_req > start > key_req when inputs coincide in the same cycle.
REQ-015 SHALL assert busy in every state except IDLE.
REQ-016 SHALL use one down-counter, at least 26 bits wide, loaded with N-1 on state entry; a state exits when the counter reaches 0.
REQ-017 SHALL register all outputs; state-driven outputs change on the same edge as the state transition.
REQ-018 SHALL wrap pat_addr from 31 to 0 only at sequence end; it never advances beyond n-1.

Reset
REQ-019 SHALL, while reset=1, asynchronously force state=IDLE, half_wav=0, audio_res=1, lamp=0, busy=0, done=0, pat_addr=0, step=0, counter=0.
REQ-020 SHALL, on reset asserted mid-sequence, produce no done pulse and ignore pending requests until reset is released.

Verification
Bench parameters: TONE_CYCLES=4, GAP_CYCLES=2, KEY_CYCLES=3, ERR_CYCLES=6.
REQ-021 Scenario: pattern {2,0,3}, start with length=3 -> lamp 3,1,4 for 4 cycles each, 2-cycle gaps, FETCH 2 cycles, half_wav 80645/119617/60241, done pulses once after the last gap.
REQ-022 Scenario: start with length=0 -> done=1 for 1 cycle the next cycle; audio_res stays 1 and busy stays 0.
REQ-023 Scenario: key_req with key_color=1 in IDLE, then key_req with color 3 on the 2nd KEY cycle -> lamp=2 then lamp=4, KEY lasts 3 cycles from the retrigger.
REQ-024 Scenario: err_req during the TONE of step 1 -> lamp=5, half_wav=595238 for 6 cycles, then IDLE, no done pulse.
REQ-025 Scenario: start and key_req in the same cycle -> sequence runs and the key tone is dropped; key_req during GAP is ignored.
REQ-026 Scenario: reset pulse during GAP -> all outputs return to their reset values immediately; a subsequent start replays from pat_addr=0.
